// File: rtl/ntt_mlkem_masked_ct_butterfly.sv
// Masked Cooley-Tukey butterfly for the forward ML-KEM NTT: u' = u + w*v, v' = u - w*v (mod 3329)
// on two-share arithmetic-masked operands, with a 15-clock pipeline, valid tracking and busy flag.

module ntt_mlkem_pipe_dly #(
  parameter int W = 1,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] stg_d [N];
  logic [W-1:0] stg_q [N];

  always_comb begin
    stg_d[0] = clr ? '0 : d_i;
    for (int i = 1; i < N; i++) begin
      stg_d[i] = clr ? '0 : stg_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) stg_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) stg_q[i] <= stg_d[i];
    end
  end

  assign q_o = stg_q[N-1];
endmodule

module ntt_mlkem_masked_BFU_mult #(
  parameter int WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [1:0][WIDTH-1:0] a_i,
  input  logic [1:0][WIDTH-1:0] b_i,
  input  logic [69:0]           rnd,
  input  logic [23:0]           rnd_24bit,
  output logic [1:0][WIDTH-1:0] c_o
);
  localparam logic [WIDTH-1:0] Q = WIDTH'(3329);

  logic [23:0]            mask24;
  logic [WIDTH-1:0]       mask, split_m;
  logic [3:0][WIDTH-1:0]  term_d, term_q;
  logic [1:0][WIDTH-1:0]  sh_d, sh_q, split_d, split_q;
  logic [WIDTH-1:0]       sum_d, sum_q, red_d, red_q;

  // Cross-domain products are blinded by a fresh mask before being registered,
  // so inner and cross terms never meet in the same combinational cone.
  always_comb begin
    mask24     = rnd[23:0] ^ rnd[47:24] ^ {2'b00, rnd[69:48]};
    mask       = WIDTH'(mask24);
    split_m    = WIDTH'(rnd_24bit);
    term_d[0]  = a_i[0] * b_i[0];
    term_d[1]  = a_i[0] * b_i[1] + mask;
    term_d[2]  = a_i[1] * b_i[1];
    term_d[3]  = a_i[1] * b_i[0] - mask;
    sh_d[0]    = term_q[0] + term_q[1];
    sh_d[1]    = term_q[2] + term_q[3];
    sum_d      = sh_q[0] + sh_q[1];
    red_d      = sum_q % Q;
    split_d[0] = red_q - split_m;
    split_d[1] = split_m;
    if (clr) begin
      term_d  = '0;
      sh_d    = '0;
      sum_d   = '0;
      red_d   = '0;
      split_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      term_q  <= '0;
      sh_q    <= '0;
      sum_q   <= '0;
      red_q   <= '0;
      split_q <= '0;
    end else begin
      term_q  <= term_d;
      sh_q    <= sh_d;
      sum_q   <= sum_d;
      red_q   <= red_d;
      split_q <= split_d;
    end
  end

  ntt_mlkem_pipe_dly #(.W(2*WIDTH), .N(3)) u_out_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .d_i   (split_q),
    .q_o   (c_o)
  );
endmodule

module ntt_mlkem_masked_BFU_add_sub #(
  parameter int WIDTH = 24,
  parameter bit SUB   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [1:0][WIDTH-1:0] a_i,
  input  logic [1:0][WIDTH-1:0] b_i,
  input  logic [55:0]           rnd,
  input  logic [23:0]           rnd_24bit,
  output logic [1:0][WIDTH-1:0] c_o
);
  localparam logic [WIDTH-1:0] Q = WIDTH'(3329);

  logic [23:0]           mask24;
  logic [WIDTH-1:0]      mask, split_m;
  logic [1:0][WIDTH-1:0] d_d, d_q, split_d, split_q;
  logic [WIDTH-1:0]      sum_d, sum_q, red_d, red_q;

  always_comb begin
    mask24  = rnd[23:0] ^ rnd[47:24] ^ {16'h0000, rnd[55:48]};
    mask    = WIDTH'(mask24);
    split_m = WIDTH'(rnd_24bit);
    if (SUB) begin
      d_d[0] = a_i[0] - b_i[0] + mask;
      d_d[1] = a_i[1] - b_i[1] - mask;
    end else begin
      d_d[0] = a_i[0] + b_i[0] + mask;
      d_d[1] = a_i[1] + b_i[1] - mask;
    end
    sum_d = d_q[0] + d_q[1];
    // Both operands are below q, so one conditional correction lands in [0, q).
    if (SUB) red_d = sum_q[WIDTH-1] ? sum_q + Q : sum_q;
    else     red_d = (sum_q >= Q) ? sum_q - Q : sum_q;
    split_d[0] = red_q - split_m;
    split_d[1] = split_m;
    if (clr) begin
      d_d     = '0;
      sum_d   = '0;
      red_d   = '0;
      split_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q     <= '0;
      sum_q   <= '0;
      red_q   <= '0;
      split_q <= '0;
    end else begin
      d_q     <= d_d;
      sum_q   <= sum_d;
      red_q   <= red_d;
      split_q <= split_d;
    end
  end

  ntt_mlkem_pipe_dly #(.W(2*WIDTH), .N(3)) u_out_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .d_i   (split_q),
    .q_o   (c_o)
  );
endmodule

module ntt_mlkem_masked_ct_butterfly #(
  parameter int WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  zeroize,
  input  logic                  valid_i,
  input  logic [1:0][WIDTH-1:0] opu_i,
  input  logic [1:0][WIDTH-1:0] opv_i,
  input  logic [1:0][WIDTH-1:0] opw_i,
  input  logic [4:0][13:0]      rnd_i,
  output logic [1:0][WIDTH-1:0] u_o,
  output logic [1:0][WIDTH-1:0] v_o,
  output logic                  valid_o,
  output logic                  busy_o
);
  localparam int               LAT = 15;
  localparam logic [WIDTH-1:0] Q   = WIDTH'(3329);

  logic                  rst_n;
  logic [1:0][WIDTH-1:0] wv, u_dly;
  logic [LAT-1:0]        vld_d, vld_q;

  assign rst_n = ~reset;

  ntt_mlkem_masked_BFU_mult #(.WIDTH(WIDTH)) u_mult (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (zeroize),
    .a_i       (opw_i),
    .b_i       (opv_i),
    .rnd       ({rnd_i[0], rnd_i[1], rnd_i[2], rnd_i[3], rnd_i[4]}),
    .rnd_24bit ({rnd_i[4][9:0], rnd_i[0]}),
    .c_o       (wv)
  );

  // u waits out the multiplier latency share-by-share in plain flops.
  ntt_mlkem_pipe_dly #(.W(2*WIDTH), .N(8)) u_u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (zeroize),
    .d_i   (opu_i),
    .q_o   (u_dly)
  );

  ntt_mlkem_masked_BFU_add_sub #(.WIDTH(WIDTH), .SUB(1'b0)) u_add (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (zeroize),
    .a_i       (u_dly),
    .b_i       (wv),
    .rnd       (rnd_i[3:0]),
    .rnd_24bit ({rnd_i[0][9:0], rnd_i[4]}),
    .c_o       (u_o)
  );

  ntt_mlkem_masked_BFU_add_sub #(.WIDTH(WIDTH), .SUB(1'b1)) u_sub (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (zeroize),
    .a_i       (u_dly),
    .b_i       (wv),
    .rnd       (rnd_i[4:1]),
    .rnd_24bit ({rnd_i[1][9:0], rnd_i[0]}),
    .c_o       (v_o)
  );

  always_comb begin
    vld_d = {vld_q[LAT-2:0], valid_i};
    if (zeroize) vld_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_q <= '0;
    else       vld_q <= vld_d;
  end

  assign valid_o = vld_q[LAT-1];
  assign busy_o  = |vld_q;

  a_operand_range : assert property (@(posedge clk) disable iff (reset)
    (valid_i && !zeroize) |-> (((opu_i[0] + opu_i[1]) < Q) &&
                               ((opv_i[0] + opv_i[1]) < Q) &&
                               ((opw_i[0] + opw_i[1]) < Q)));
endmodule
